// File: rtl/ode_sender_pkg.sv
// Shared definitions for the sender datapath: burst-reader FSM state codes and
// default widths used by both the RAM reader and the serializer.
package ode_sender_pkg;

  localparam int ADDRESS_WIDTH_DEF = 13;
  localparam int DATA_WIDTH_DEF    = 64;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_READ   = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/ram_burst_reader_sync_fifo2.sv
// Two-entry synchronous FIFO carrying {last, data}. Head entry is presented
// combinationally from storage; push and pop may happen in the same cycle, even when full.
module sync_fifo2 #(
  parameter int W = 65
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  // When full, wr_ptr == rd_ptr: a simultaneous push overwrites the slot being popped.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read master: walks a wrapping RAM address range and streams words out.
// Define RAM_BURST_READER_CHECKSUM_EN to append an XOR checksum word to each non-empty burst.
module ram_burst_reader
  import ode_sender_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   word_count,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  localparam int CW = ADDRESS_WIDTH + 2;

  state_t                 state;
  logic [CW-1:0]          remaining;
  logic [CW-1:0]          total;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   push_last;
  logic [DATA_WIDTH-1:0]  push_data;
  logic [DATA_WIDTH:0]    fifo_head;

  assign pop       = out_valid & out_ready;
  assign push      = (state == ST_READ) && (!fifo_full || pop);
  assign push_last = (remaining == CW'(1));

`ifdef RAM_BURST_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;

  // One extra slot in the burst for the checksum word.
  assign total     = CW'(word_count) + CW'(word_count != '0);
  assign push_data = push_last ? csum : rd_data;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      csum <= '0;
    end else if (state == ST_IDLE && start) begin
      csum <= '0;
    end else if (push && !push_last) begin
      csum <= csum ^ rd_data;
    end
  end
`else
  assign total     = CW'(word_count);
  assign push_data = rd_data;
`endif

  sync_fifo2 #(.W(DATA_WIDTH + 1)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push),
    .push_data ({push_last, push_data}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_last  = fifo_head[DATA_WIDTH];
  assign out_data  = fifo_head[DATA_WIDTH-1:0];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= ST_IDLE;
      rd_addr   <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rd_addr   <= base_addr;
            remaining <= total;
            state     <= (word_count == '0) ? ST_FINISH : ST_READ;
          end
        end
        ST_READ: begin
          if (push) begin
            rd_addr   <= rd_addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (push_last) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && out_last) begin
            state <= ST_FINISH;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FINISH);

endmodule

// File: tb/tb_ram_burst_reader.sv
// Randomized bench for ram_burst_reader: a RAM array plus a queue-based model of
// the expected stream, covering timing, backpressure, wrap, empty bursts and reset abort.
module tb_ram_burst_reader;

  localparam int AW = 13;
  localparam int DW = 64;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  assign rd_data = ram[rd_addr];

  ram_burst_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  // mode 0: ready always 1; mode 1: random ready plus a start while busy; mode 2: ready 1,0,0,1 pattern
  task automatic run_burst(input logic [AW-1:0] base, input logic [AW:0] cnt, input int mode,
                           input string name);
    logic [DW:0]   exp_q[$];
    logic [DW:0]   exp_w;
    logic [DW:0]   held;
    logic [DW-1:0] x;
    logic [AW-1:0] a;
    logic          stalled;
    int            nwords, first_v, last_hs, done_cyc, busy_cnt, budget;
    x = '0;
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + AW'(i);
      x = x ^ ram[a];
`ifdef RAM_BURST_READER_CHECKSUM_EN
      exp_q.push_back({1'b0, ram[a]});
`else
      exp_q.push_back({(i == int'(cnt) - 1), ram[a]});
`endif
    end
`ifdef RAM_BURST_READER_CHECKSUM_EN
    if (cnt != 0) exp_q.push_back({1'b1, x});
`endif
    nwords   = exp_q.size();
    first_v  = -1;
    last_hs  = -1;
    done_cyc = -1;
    busy_cnt = 0;
    stalled  = 1'b0;
    held     = '0;
    budget   = 20 * int'(cnt) + 20;

    @(negedge CLK);
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    @(posedge CLK);
    #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    checks++;
    if (busy !== 1'b1 || rd_addr !== base) begin
      failures++;
      $display("FAIL %s accept: busy=%b rd_addr=%h required busy=1 rd_addr=%h", name, busy, rd_addr, base);
    end

    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge CLK);
      start = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom);
        default: out_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
      endcase
      if (mode == 1 && cyc == 3 && cnt != 0) begin
        start      = 1'b1;
        base_addr  = base + 13'h0555;
        word_count = 14'd7;
      end
      if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        if (stalled) begin
          checks++;
          if ({out_last, out_data} !== held) begin
            failures++;
            $display("FAIL %s stall_hold: got %h required %h", name, {out_last, out_data}, held);
          end
        end
      end
      if (out_valid && out_ready) begin
        stalled = 1'b0;
        last_hs = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s extra_word: got %h required none", name, {out_last, out_data});
        end else begin
          exp_w = exp_q.pop_front();
          if ({out_last, out_data} !== exp_w) begin
            failures++;
            $display("FAIL %s word: got last=%b data=%h required last=%b data=%h",
                     name, out_last, out_data, exp_w[DW], exp_w[DW-1:0]);
          end
        end
      end else if (out_valid) begin
        stalled = 1'b1;
        held    = {out_last, out_data};
      end
      if (busy) busy_cnt++;
      if (done) begin
        if (done_cyc >= 0) begin
          checks++;
          failures++;
          $display("FAIL %s done_twice: got done at %0d required single pulse at %0d", name, cyc, done_cyc);
        end else begin
          done_cyc = cyc;
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    start     = 1'b0;
    out_ready = 1'b0;

    checks++;
    if (exp_q.size() != 0 || done_cyc < 0) begin
      failures++;
      $display("FAIL %s completion: words_left=%0d done_cycle=%0d required 0 and >=1", name, exp_q.size(), done_cyc);
    end
    checks++;
    if (done_cyc != ((nwords == 0) ? 1 : last_hs + 1)) begin
      failures++;
      $display("FAIL %s done_timing: got %0d required %0d", name, done_cyc, (nwords == 0) ? 1 : last_hs + 1);
    end
    checks++;
    if (busy_cnt != done_cyc) begin
      failures++;
      $display("FAIL %s busy_span: got %0d cycles required %0d", name, busy_cnt, done_cyc);
    end
    if (nwords != 0) begin
      checks++;
      if (first_v != 2) begin
        failures++;
        $display("FAIL %s first_valid: got cycle %0d required 2", name, first_v);
      end
      if (mode == 0) begin
        checks++;
        if (last_hs != first_v + nwords - 1) begin
          failures++;
          $display("FAIL %s throughput: last at %0d required %0d", name, last_hs, first_v + nwords - 1);
        end
      end
    end else begin
      checks++;
      if (first_v != -1) begin
        failures++;
        $display("FAIL %s empty_valid: got valid at %0d required never", name, first_v);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({busy, done, rd_addr, out_valid, out_last, out_data} !== '0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b rd_addr=%h valid=%b last=%b data=%h required all 0",
               busy, done, rd_addr, out_valid, out_last, out_data);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
    run_burst(13'h010, 14'd4, 0, "basic");
  endtask

  task automatic test_backpressure();
    run_burst(13'h010, 14'd4, 2, "ready_pattern");
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 64; i++) ram[(t * 700 + i) % (1 << AW)] = {$urandom, $urandom};
      run_burst(AW'(t * 700), AW'(1 + $urandom_range(0, 40)) , 1, "random_ready");
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
    run_burst(13'h1FFE, 14'd4, 0, "wrap");
    run_burst(13'h1FFF, 14'd3, 1, "wrap_random");
  endtask

  task automatic test_zero_count();
    run_burst(13'h0123, 14'd0, 0, "zero_count");
  endtask

  task automatic test_reset_abort();
    int hs;
    int got_valid;
    hs = 0;
    @(negedge CLK);
    start      = 1'b1;
    base_addr  = 13'h0100;
    word_count = 14'd8;
    out_ready  = 1'b1;
    for (int cyc = 0; cyc < 20 && hs < 2; cyc++) begin
      @(negedge CLK);
      start = 1'b0;
      if (out_valid && out_ready) hs++;
    end
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (hs != 2 || {busy, done, rd_addr, out_valid, out_last, out_data} !== '0) begin
      failures++;
      $display("FAIL reset_abort: words=%0d busy=%b done=%b rd_addr=%h valid=%b last=%b data=%h required 2 words then all 0",
               hs, busy, done, rd_addr, out_valid, out_last, out_data);
    end
    @(negedge CLK);
    RST = 1'b1;
    got_valid = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge CLK);
      if (out_valid || done || busy) got_valid++;
    end
    out_ready = 1'b0;
    checks++;
    if (got_valid != 0) begin
      failures++;
      $display("FAIL reset_quiet: got %0d active cycles required 0", got_valid);
    end
    run_burst(13'h0200, 14'd5, 0, "restart");
  endtask

  task automatic test_checksum();
    ram[13'h0300] = 64'hA5;
    ram[13'h0301] = 64'h5A;
    ram[13'h0302] = 64'hFF;
    run_burst(13'h0300, 14'd3, 0, "checksum");
    run_burst(13'h0300, 14'd3, 2, "checksum_stall");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 128; i++) ram[13'h0400 + 13'(i)] = {$urandom, $urandom};
    run_burst(13'h0400, 14'd9, 0, "b2b_a");
    run_burst(13'h0409, 14'd1, 0, "b2b_b");
    run_burst(13'h040A, 14'd2, 1, "b2b_c");
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_count();
    test_reset_abort();
    test_checksum();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
